pe_row_conv: RTL and testbench

Parametrised row-convolution processing element. It streams one activation row per pass through a K-tap signed weight window and accumulates partial sums across K kernel rows in an internal line buffer. Finished outputs go into an output FIFO with valid/ready backpressure. It sits between the activation row broadcaster and the psum collector in the core, and it generalises the fixed 3/5-tap PE to arbitrary kernel size, row length, psum width and FIFO depth.

---
 rtl/pe_row_conv_if.sv | 24 ++
 rtl/pe_row_conv.sv | 213 +++++++++++++++++++++
 tb/tb_pe_row_conv.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_row_conv_if.sv
// Streaming bus for the row-convolution PE.
// The activation input stream and the psum output stream share this bundle.
// The PE side uses the slave modport; the producer/consumer side uses master.
interface pe_row_conv_if #(
    parameter int ACT_W  = 8,
    parameter int PSUM_W = 20
);
    logic              act_valid;
    logic              act_ready;
    logic [ACT_W-1:0]  act_i;
    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] out_data;

    modport master (
        output act_valid, act_i, out_ready,
        input  act_ready, out_valid, out_data
    );

    modport slave (
        input  act_valid, act_i, out_ready,
        output act_ready, out_valid, out_data
    );
endinterface

// File: rtl/pe_row_conv.sv
// Row-convolution processing element.
// A K-tap signed weight window slides over one unsigned activation row per pass.
// Partial sums accumulate across kernel rows in a line buffer. The last kernel row
// pushes saturated results into a first-word-fall-through output FIFO.
module pe_row_conv #(
    parameter int ACT_W      = 8,
    parameter int WGT_W      = 8,
    parameter int K          = 3,
    parameter int ROW_LEN    = 16,
    parameter int PSUM_W     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wgt_load,
    input  logic [K*WGT_W-1:0] wgt_i,
    input  logic               start,
    input  logic               first_row,
    input  logic               last_row,
    pe_row_conv_if.slave       bus,
    output logic               busy,
    output logic               row_done,
    output logic               sat_flag
);
    localparam int OUT_LEN = ROW_LEN - K + 1;
    localparam int CNT_W   = $clog2(ROW_LEN + 1);
    localparam int IDX_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FC_W    = $clog2(FIFO_DEPTH + 1);
    localparam int DOT_W   = ACT_W + WGT_W + 1 + $clog2(K + 1);
    localparam int SUM_W   = ((DOT_W > PSUM_W) ? DOT_W : PSUM_W) + 1;
    localparam logic signed [SUM_W-1:0] PMAX = {{(SUM_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] PMIN = {{(SUM_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

    // Clamp to the psum range; MSB of the result flags that clamping happened.
    function automatic logic [PSUM_W:0] sat_fn(input logic signed [SUM_W-1:0] v);
        logic [PSUM_W:0] r;
        if (v > PMAX) begin
            r = {1'b1, PMAX[PSUM_W-1:0]};
        end else if (v < PMIN) begin
            r = {1'b1, PMIN[PSUM_W-1:0]};
        end else begin
            r = {1'b0, v[PSUM_W-1:0]};
        end
        return r;
    endfunction

    // Circular pointer advance for a FIFO depth that need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    state_t                    state_r, state_s;
    logic                      first_r, last_r, sat_r, busy_r, row_done_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [K*WGT_W-1:0]        wgt_r;
    logic [ACT_W-1:0]          win_r  [K];
    logic [ACT_W-1:0]          nwin_s [K];
    logic signed [DOT_W-1:0]   dot_s, p1_dot_r;
    logic                      p1_valid_r;
    logic [IDX_W-1:0]          p1_idx_r;
    logic signed [PSUM_W-1:0]  lbuf_r [OUT_LEN];
    logic signed [SUM_W-1:0]   sum_s;
    logic                      sat_hit_s;
    logic [PSUM_W-1:0]         sat_val_s;
    logic [PSUM_W-1:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
    logic [FC_W-1:0]           fifo_cnt_r;
    logic [FC_W:0]             occ_s;
    logic                      start_ok_s, accept_s, last_acc_s, produce_s, push_s, pop_s;

    // Handshake decode. Occupancy counts a pending P1 push but not a same-cycle pop.
    assign start_ok_s    = (state_r == S_IDLE) && start;
    assign occ_s         = {1'b0, fifo_cnt_r} + {{FC_W{1'b0}}, (p1_valid_r && last_r)};
    assign bus.act_ready = (state_r == S_RUN) && (!last_r || (occ_s < (FC_W+1)'(FIFO_DEPTH)));
    assign accept_s      = bus.act_valid && bus.act_ready;
    assign last_acc_s    = accept_s && (cnt_r == CNT_W'(ROW_LEN - 1));
    assign produce_s     = accept_s && (cnt_r >= CNT_W'(K - 1));
    assign push_s        = p1_valid_r && last_r;
    assign pop_s         = bus.out_valid && bus.out_ready;
    assign bus.out_valid = (fifo_cnt_r != FC_W'(0));
    assign bus.out_data  = fifo_mem_r[rd_ptr_r];
    assign busy          = busy_r;
    assign row_done      = row_done_r;
    assign sat_flag      = sat_r;

    // Window as it will look after the current accept, and its dot product.
    always_comb begin
        nwin_s[K-1] = bus.act_i;
        for (int k = 0; k < K - 1; k++) begin
            nwin_s[k] = win_r[k+1];
        end
        dot_s = '0;
        for (int k = 0; k < K; k++) begin
            dot_s = dot_s + (DOT_W'($signed({1'b0, nwin_s[k]})) *
                             DOT_W'($signed(wgt_r[k*WGT_W +: WGT_W])));
        end
    end

    // P1 retire value: fresh dot on the first row, otherwise accumulate onto the buffer.
    always_comb begin
        if (first_r) begin
            sum_s = SUM_W'(p1_dot_r);
        end else begin
            sum_s = SUM_W'(lbuf_r[p1_idx_r]) + SUM_W'(p1_dot_r);
        end
        {sat_hit_s, sat_val_s} = sat_fn(sum_s);
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (start) state_s = S_RUN; else state_s = S_IDLE;
            S_RUN:   if (last_acc_s) state_s = S_FLUSH; else state_s = S_RUN;
            S_FLUSH: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus registered busy and row_done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            busy_r     <= 1'b0;
            row_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != S_IDLE);
            row_done_r <= (state_s == S_FLUSH);
        end
    end

    // Weights, row flags, accept counter and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt_r   <= '0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            cnt_r   <= '0;
            sat_r   <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && wgt_load) wgt_r <= wgt_i;
            if (start_ok_s) begin
                first_r <= first_row;
                last_r  <= last_row;
                cnt_r   <= '0;
            end else if (accept_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (start_ok_s) sat_r <= 1'b0;
            else if (p1_valid_r && sat_hit_s) sat_r <= 1'b1;
        end
    end

    // Activation window: cleared at pass start, shifted on each accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < K; k++) win_r[k] <= '0;
        end else if (start_ok_s) begin
            for (int k = 0; k < K; k++) win_r[k] <= '0;
        end else if (accept_s) begin
            for (int k = 0; k < K; k++) win_r[k] <= nwin_s[k];
        end
    end

    // P1 product register with its output column index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_r <= 1'b0;
            p1_dot_r   <= '0;
            p1_idx_r   <= '0;
        end else begin
            p1_valid_r <= produce_s;
            if (produce_s) begin
                p1_dot_r <= dot_s;
                p1_idx_r <= IDX_W'(cnt_r - CNT_W'(K - 1));
            end
        end
    end

    // Line buffer holds partial sums between kernel rows; untouched by the last row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_LEN; i++) lbuf_r[i] <= '0;
        end else if (p1_valid_r && !last_r) begin
            lbuf_r[p1_idx_r] <= sat_val_s;
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= sat_val_s;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + FC_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - FC_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_row_conv.sv
// Directed, table-driven bench for pe_row_conv.
// Instance A (FIFO depth 4) runs the pass table.
// Instance B (FIFO depth 2) covers output backpressure.
module tb_pe_row_conv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wgt_load = 1'b0, start = 1'b0, wgt_load_b = 1'b0, start_b = 1'b0;
    logic        first_row = 1'b0, last_row = 1'b0;
    logic [23:0] wgt_i = 24'h0;
    logic        busy_a, row_done_a, sat_a, busy_b, row_done_b, sat_b;
    int          checks = 0, errors = 0, cyc = 0;
    int          qa[$], ta[$], qb[$];

    always #5 clk = ~clk;

    pe_row_conv_if #(.ACT_W(8), .PSUM_W(12)) ifa ();
    pe_row_conv_if #(.ACT_W(8), .PSUM_W(12)) ifb ();

    pe_row_conv #(.ACT_W(8), .WGT_W(8), .K(3), .ROW_LEN(5), .PSUM_W(12), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .wgt_load(wgt_load), .wgt_i(wgt_i), .start(start),
        .first_row(first_row), .last_row(last_row), .bus(ifa),
        .busy(busy_a), .row_done(row_done_a), .sat_flag(sat_a));

    pe_row_conv #(.ACT_W(8), .WGT_W(8), .K(3), .ROW_LEN(5), .PSUM_W(12), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .wgt_load(wgt_load_b), .wgt_i(wgt_i), .start(start_b),
        .first_row(first_row), .last_row(last_row), .bus(ifb),
        .busy(busy_b), .row_done(row_done_b), .sat_flag(sat_b));

    typedef struct {
        bit          f, l;
        logic [23:0] w;      // tap k at [k*8 +: 8]
        logic [39:0] a;      // activation i at [i*8 +: 8]
        int          n;      // expected output count
        int          e0, e1, e2;
        bit          s;      // expected sat_flag after the pass
        bit          stall, pulse, timing;
    } vec_t;

    vec_t vt[9];

    // Cycle counter and output monitors, sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ifa.out_valid && ifa.out_ready) begin
            qa.push_back(int'($signed(ifa.out_data)));
            ta.push_back(cyc);
        end
        if (ifb.out_valid && ifb.out_ready) qb.push_back(int'($signed(ifb.out_data)));
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(bit f, bit l, logic [23:0] w, logic [39:0] a, int n,
                                int e0, int e1, int e2, bit s, bit st, bit pu, bit tm);
        vec_t v;
        v.f = f; v.l = l; v.w = w; v.a = a; v.n = n;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.s = s;
        v.stall = st; v.pulse = pu; v.timing = tm;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [7:0] v, output int acyc, output bit ok);
        ifa.act_valid = 1'b1;
        ifa.act_i     = v;
        ok            = 1'b0;
        acyc          = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (ifa.act_ready) begin
                ok   = 1'b1;
                acyc = cyc;
            end
            tick();
        end
        ifa.act_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int ac, acc3;
        bit ok;
        int ex[3];
        ex[0] = v.e0; ex[1] = v.e1; ex[2] = v.e2;
        acc3 = 0;
        qa.delete();
        ta.delete();
        wgt_i = v.w; wgt_load = 1'b1; tick(); wgt_load = 1'b0;
        first_row = v.f; last_row = v.l; start = 1'b1; tick(); start = 1'b0;
        chk($sformatf("v%0d_busy_start", idx), busy_a, 1);
        chk($sformatf("v%0d_sat_cleared", idx), sat_a, 0);
        for (int i = 0; i < 5; i++) begin
            if (v.stall) repeat ($urandom_range(0, 2)) tick();
            if (v.pulse && i == 2) begin
                start = 1'b1; wgt_load = 1'b1; wgt_i = 24'h0;
                first_row = ~v.f; last_row = ~v.l;
                tick();
                start = 1'b0; wgt_load = 1'b0; first_row = v.f; last_row = v.l;
            end
            feed_a(v.a[i*8 +: 8], ac, ok);
            chk($sformatf("v%0d_accept%0d", idx, i), ok, 1);
            if (i == 2) acc3 = ac;
        end
        chk($sformatf("v%0d_row_done", idx), row_done_a, 1);
        tick();
        chk($sformatf("v%0d_busy_end", idx), busy_a, 0);
        chk($sformatf("v%0d_row_done_pulse", idx), row_done_a, 0);
        repeat (4) tick();
        chk($sformatf("v%0d_nout", idx), qa.size(), v.n);
        for (int i = 0; i < v.n && i < qa.size(); i++)
            chk($sformatf("v%0d_out%0d", idx, i), qa[i], ex[i]);
        if (v.timing && qa.size() == 3) begin
            chk($sformatf("v%0d_first_latency", idx), ta[0] - acc3, 2);
            chk($sformatf("v%0d_consecutive", idx), ta[2] - ta[0], 2);
        end
        chk($sformatf("v%0d_sat_flag", idx), sat_a, v.s);
    endtask

    initial begin
        int ac, nacc;
        bit ok;
        ifa.act_valid = 1'b0; ifa.act_i = 8'h0; ifa.out_ready = 1'b1;
        ifb.act_valid = 1'b0; ifb.act_i = 8'h0; ifb.out_ready = 1'b0;

        vt[0] = mk(1'b1, 1'b1, 24'h030201, 40'h0504030201, 3,    14,    20,    26, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[1] = mk(1'b1, 1'b0, 24'h030201, 40'h0504030201, 0,     0,     0,     0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[2] = mk(1'b0, 1'b0, 24'h030201, 40'h0504030201, 0,     0,     0,     0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[3] = mk(1'b0, 1'b1, 24'h030201, 40'h0504030201, 3,    42,    60,    78, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[4] = mk(1'b1, 1'b1, 24'h7f7f7f, 40'hffffffffff, 3,  2047,  2047,  2047, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[5] = mk(1'b1, 1'b1, 24'h808080, 40'hffffffffff, 3, -2048, -2048, -2048, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[6] = mk(1'b1, 1'b1, 24'h030201, 40'h0504030201, 3,    14,    20,    26, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[7] = mk(1'b1, 1'b1, 24'h0200ff, 40'h0703ff000a, 3,   500,     6,  -241, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[8] = mk(1'b1, 1'b1, 24'h030201, 40'h0504030201, 3,    14,    20,    26, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset values.
        #2;
        chk("rst_act_ready", ifa.act_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_data", ifa.out_data, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_row_done", row_done_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_b_busy", busy_b | row_done_b | sat_b | ifb.out_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

        // Reset mid-pass: one output already sits in the FIFO and must be discarded.
        wgt_i = 24'h030201; wgt_load = 1'b1; tick(); wgt_load = 1'b0;
        first_row = 1'b1; last_row = 1'b1; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) feed_a(8'(i + 1), ac, ok);
        tick();
        chk("midrst_pre_valid", ifa.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_act_ready", ifa.act_ready, 0);
        chk("midrst_out_valid", ifa.out_valid, 0);
        chk("midrst_out_data", ifa.out_data, 0);
        chk("midrst_row_done", row_done_a, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        run_vec(9, vt[0]);

        // Backpressure on the depth-2 instance.
        wgt_i = 24'h030201; wgt_load_b = 1'b1; tick(); wgt_load_b = 1'b0;
        first_row = 1'b1; last_row = 1'b1; start_b = 1'b1; tick(); start_b = 1'b0;
        qb.delete();
        nacc = 0;
        ifb.out_ready = 1'b0; ifb.act_valid = 1'b1; ifb.act_i = 8'd1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifb.act_valid && ifb.act_ready) nacc++;
            tick();
            ifb.act_i = 8'(nacc + 1);
            if (nacc == 5) ifb.act_valid = 1'b0;
        end
        chk("bp_accepts_stalled", nacc, 4);
        chk("bp_ready_low", ifb.act_ready, 0);
        chk("bp_head_valid", ifb.out_valid, 1);
        chk("bp_head_data", int'($signed(ifb.out_data)), 14);
        chk("bp_no_pop", qb.size(), 0);
        ifb.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifb.act_valid && ifb.act_ready) nacc++;
            tick();
            ifb.act_i = 8'(nacc + 1);
            if (nacc == 5) ifb.act_valid = 1'b0;
        end
        chk("bp_accepts_total", nacc, 5);
        chk("bp_nout", qb.size(), 3);
        if (qb.size() == 3) begin
            chk("bp_out0", qb[0], 14);
            chk("bp_out1", qb[1], 20);
            chk("bp_out2", qb[2], 26);
        end
        chk("bp_busy_end", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
